// File: rtl/debug_display_pkg.sv
// Shared definitions for the debug VGA overlay sequencer.
// Holds the 640x480@60 timing constants and derived totals, the capture FSM
// state type, and the field layout of the debug snapshot bus so the renderer
// can slice dbg_out consistently.
package debug_display_pkg;

    // Scan coordinate width (x and y)
    localparam int unsigned COORD_W = 11;

    // Horizontal timing in pixels
    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    // Debug snapshot bus layout, LSB first
    localparam int unsigned HEAP_LSB  = 0;
    localparam int unsigned HEAP_W    = 176;
    localparam int unsigned IFPC_LSB  = HEAP_LSB + HEAP_W;
    localparam int unsigned IFPC_W    = 16;
    localparam int unsigned IFIR_LSB  = IFPC_LSB + IFPC_W;
    localparam int unsigned IFIR_W    = 16;
    localparam int unsigned RIDX_LSB  = IFIR_LSB + IFIR_W;
    localparam int unsigned RIDX_W    = 16;
    localparam int unsigned EXRES_LSB = RIDX_LSB + RIDX_W;
    localparam int unsigned EXRES_W   = 16;
    localparam int unsigned MERES_LSB = EXRES_LSB + EXRES_W;
    localparam int unsigned MERES_W   = 16;
    localparam int unsigned DBG_W     = MERES_LSB + MERES_W;

    // Same layout as a packed payload (first member is the MSB end)
    typedef struct packed {
        logic [MERES_W-1:0] me_result;
        logic [EXRES_W-1:0] ex_result;
        logic [RIDX_W-1:0]  reg_idx;
        logic [IFIR_W-1:0]  if_ir;
        logic [IFPC_W-1:0]  if_pc;
        logic [HEAP_W-1:0]  reg_heap;
    } dbg_snap_t;

    // Capture FSM states
    typedef enum logic [1:0] {
        CAP_LIVE  = 2'd0,
        CAP_HOLD  = 2'd1,
        CAP_ARMED = 2'd2
    } cap_state_e;

endpackage

// File: rtl/debug_display_sequencer_vga_timing_counter.sv
// Raster timing generator for the debug overlay.
// Ports: clk/rst (sync, active-high), pix_en pixel tick; outputs x/y scan
// coordinates, active-low hsync/vsync, active (visible area), frame_start
// (one-clk pulse on wrap to 0,0) and ce_c, a combinational strobe that is
// high in the cycle whose edge moves the raster to (0, V_VIS).
module vga_timing_counter
#(
    parameter int unsigned H_VIS  = debug_display_pkg::H_VIS,
    parameter int unsigned H_FP   = debug_display_pkg::H_FP,
    parameter int unsigned H_SYNC = debug_display_pkg::H_SYNC,
    parameter int unsigned H_BP   = debug_display_pkg::H_BP,
    parameter int unsigned V_VIS  = debug_display_pkg::V_VIS,
    parameter int unsigned V_FP   = debug_display_pkg::V_FP,
    parameter int unsigned V_SYNC = debug_display_pkg::V_SYNC,
    parameter int unsigned V_BP   = debug_display_pkg::V_BP
)
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_en,
    output logic [debug_display_pkg::COORD_W-1:0] x,
    output logic [debug_display_pkg::COORD_W-1:0] y,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 active,
    output logic                                 frame_start,
    output logic                                 ce_c
);
    import debug_display_pkg::*;

    localparam int unsigned H_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_LEN    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               frame_start_q, frame_start_d;
    logic               x_last_c;
    logic               y_last_c;

    // Next raster position; sync/active derived from it so they move with x/y
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        x_last_c      = (x_q == COORD_W'(H_LEN - 1));
        y_last_c      = (y_q == COORD_W'(V_LEN - 1));
        ce_c          = pix_en && x_last_c && (y_q == COORD_W'(V_VIS - 1));

        if (pix_en) begin
            if (x_last_c) begin
                x_d = '0;
                if (y_last_c) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + COORD_W'(1);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end

        hsync_d  = !((x_d >= COORD_W'(HS_START)) && (x_d < COORD_W'(HS_END)));
        vsync_d  = !((y_d >= COORD_W'(VS_START)) && (y_d < COORD_W'(VS_END)));
        active_d = (x_d < COORD_W'(H_VIS)) && (y_d < COORD_W'(V_VIS));
    end

    // Raster registers; reset state corresponds to position (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/debug_display_sequencer.sv
// Debug VGA overlay sequencer.
// Ports: clk/rst (sync, active-high), pix_en pixel tick, dbg_in live CPU
// debug bus, freeze (level) and step (pulse) capture control; outputs the
// raster signals from vga_timing_counter plus dbg_out (per-frame snapshot
// taken at the start of vertical blanking), snap_valid and step_ack.
module debug_display_sequencer
#(
    parameter int unsigned DBG_W  = debug_display_pkg::DBG_W,
    parameter int unsigned H_VIS  = debug_display_pkg::H_VIS,
    parameter int unsigned H_FP   = debug_display_pkg::H_FP,
    parameter int unsigned H_SYNC = debug_display_pkg::H_SYNC,
    parameter int unsigned H_BP   = debug_display_pkg::H_BP,
    parameter int unsigned V_VIS  = debug_display_pkg::V_VIS,
    parameter int unsigned V_FP   = debug_display_pkg::V_FP,
    parameter int unsigned V_SYNC = debug_display_pkg::V_SYNC,
    parameter int unsigned V_BP   = debug_display_pkg::V_BP
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [DBG_W-1:0] dbg_in,
    input  logic             freeze,
    input  logic             step,
    output logic [10:0]      x,
    output logic [10:0]      y,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             frame_start,
    output logic [DBG_W-1:0] dbg_out,
    output logic             snap_valid,
    output logic             step_ack
);
    import debug_display_pkg::*;

    cap_state_e       state_q, state_d;
    logic [DBG_W-1:0] dbg_out_q, dbg_out_d;
    logic             snap_valid_q, snap_valid_d;
    logic             step_ack_q, step_ack_d;
    logic             capture_c;
    logic             ce_c;

    vga_timing_counter #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start),
        .ce_c        (ce_c)
    );

    // Capture FSM: freeze beats a coincident capture; a step arms exactly one
    always_comb begin
        state_d      = state_q;
        dbg_out_d    = dbg_out_q;
        snap_valid_d = snap_valid_q;
        step_ack_d   = 1'b0;
        capture_c    = 1'b0;

        unique case (state_q)
            CAP_LIVE: begin
                if (freeze) begin
                    state_d = CAP_HOLD;
                end else if (ce_c) begin
                    capture_c = 1'b1;
                end
            end
            CAP_HOLD: begin
                if (!freeze) begin
                    state_d = CAP_LIVE;
                end else if (step) begin
                    state_d = CAP_ARMED;
                end
            end
            CAP_ARMED: begin
                if (!freeze) begin
                    state_d = CAP_LIVE;
                end else if (ce_c) begin
                    capture_c  = 1'b1;
                    step_ack_d = 1'b1;
                    state_d    = CAP_HOLD;
                end
            end
            default: begin
                state_d = CAP_LIVE;
            end
        endcase

        if (capture_c) begin
            dbg_out_d    = dbg_in;
            snap_valid_d = 1'b1;
        end
    end

    // FSM and snapshot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CAP_LIVE;
            dbg_out_q    <= '0;
            snap_valid_q <= 1'b0;
            step_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbg_out_q    <= dbg_out_d;
            snap_valid_q <= snap_valid_d;
            step_ack_q   <= step_ack_d;
        end
    end

    assign dbg_out    = dbg_out_q;
    assign snap_valid = snap_valid_q;
    assign step_ack   = step_ack_q;

endmodule

// File: tb/tb_debug_display_sequencer.sv
// Self-checking bench for debug_display_sequencer using a reduced raster
// (24x13) so several full frames fit in a short run. The reference model
// tracks a linear pixel index and derives every expected output from it.
module tb_debug_display_sequencer;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int TOT = HT * VT;
    localparam int CE_P = VV * HT - 1;
    localparam int DW  = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_en = 1'b0;
    logic [DW-1:0] dbg_in = '0;
    logic          freeze = 1'b0;
    logic          step = 1'b0;
    logic [10:0]   x, y;
    logic          hsync, vsync, active, frame_start;
    logic [DW-1:0] dbg_out;
    logic          snap_valid, step_ack;

    int checks = 0;
    int errors = 0;

    // Model state
    int            mp = 0;
    logic [DW-1:0] m_snap = '0;
    logic          m_valid = 1'b0;
    logic          m_ack = 1'b0;
    logic          m_fs = 1'b0;
    logic          m_held = 1'b0;
    logic          m_pend = 1'b0;

    debug_display_sequencer #(
        .DBG_W(DW),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .dbg_in      (dbg_in),
        .freeze      (freeze),
        .step        (step),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start),
        .dbg_out     (dbg_out),
        .snap_valid  (snap_valid),
        .step_ack    (step_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_bus();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model of one clock edge
    task automatic model_edge(input logic r, input logic pe, input logic fr,
                              input logic st, input logic [DW-1:0] din);
        logic ce, cap;
        ce  = pe && (mp == CE_P);
        cap = 1'b0;
        if (r) begin
            mp = 0; m_snap = '0; m_valid = 1'b0; m_ack = 1'b0; m_fs = 1'b0;
            m_held = 1'b0; m_pend = 1'b0;
        end else begin
            m_ack = 1'b0;
            m_fs  = pe && (mp == TOT - 1);
            if (!m_held) begin
                if (fr) m_held = 1'b1;
                else if (ce) cap = 1'b1;
            end else if (!m_pend) begin
                if (!fr) m_held = 1'b0;
                else if (st) m_pend = 1'b1;
            end else begin
                if (!fr) begin
                    m_held = 1'b0; m_pend = 1'b0;
                end else if (ce) begin
                    cap = 1'b1; m_ack = 1'b1; m_pend = 1'b0;
                end
            end
            if (cap) begin
                m_snap  = din;
                m_valid = 1'b1;
            end
            if (pe) mp = (mp + 1) % TOT;
        end
    endtask

    task automatic compare_all();
        int ex, ey;
        ex = mp % HT;
        ey = mp / HT;
        chk("x", DW'(x), DW'(ex));
        chk("y", DW'(y), DW'(ey));
        chk("hsync", DW'(hsync), DW'(!(ex >= HV + HF && ex < HV + HF + HS)));
        chk("vsync", DW'(vsync), DW'(!(ey >= VV + VF && ey < VV + VF + VS)));
        chk("active", DW'(active), DW'(ex < HV && ey < VV));
        chk("frame_start", DW'(frame_start), DW'(m_fs));
        chk("dbg_out", dbg_out, m_snap);
        chk("snap_valid", DW'(snap_valid), DW'(m_valid));
        chk("step_ack", DW'(step_ack), DW'(m_ack));
    endtask

    task automatic tick(input logic r, input logic pe, input logic fr, input logic st);
        rst = r; pix_en = pe; freeze = fr; step = st;
        dbg_in = rand_bus();
        @(posedge clk);
        model_edge(r, pe, fr, st, dbg_in);
        #1;
        compare_all();
    endtask

    task automatic advance_to(input int target, input logic fr);
        int n = 0;
        while (mp != target && n < 2 * TOT) begin
            tick(1'b0, 1'b1, fr, 1'b0);
            n++;
        end
        chk("advance_budget", DW'(mp), DW'(target));
    endtask

    initial begin
        logic [DW-1:0] held_val;
        int            last_fs;
        logic          fr;

        // Reset
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_x", DW'(x), DW'(0));
        chk("reset_hsync", DW'(hsync), DW'(1));

        // Free run with pix_en high: frame_start period
        last_fs = -1;
        for (int i = 0; i < 2 * TOT + 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            if (frame_start) begin
                if (last_fs >= 0) chk("fs_period", DW'(i - last_fs), DW'(TOT));
                last_fs = i;
            end
        end
        chk("live_snap_valid", DW'(snap_valid), DW'(1));

        // Freeze asserted on the capture edge: snapshot must not change
        advance_to(CE_P, 1'b0);
        held_val = dbg_out;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        advance_to(CE_P, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("freeze_hold", dbg_out, held_val);

        // Single step mid-frame, capture at next CE, then hold again
        advance_to(50, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        advance_to(CE_P, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("step_ack_pulse", DW'(step_ack), DW'(1));
        held_val = dbg_out;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("step_ack_width", DW'(step_ack), DW'(0));
        advance_to(CE_P, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_step_hold", dbg_out, held_val);

        // Arm, then release freeze before CE: live capture resumes
        advance_to(40, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * TOT; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized control with sparse pix_en
        fr = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(63) == 0) fr = ~fr;
            tick(1'b0, $urandom_range(1) == 1, fr, $urandom_range(15) == 0);
        end

        // Mid-frame reset, then 1-in-4 pix_en
        advance_to(5 * HT + 7, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_y", DW'(y), DW'(0));
        chk("midreset_dbg", dbg_out, DW'(0));
        for (int i = 0; i < 1500; i++) tick(1'b0, (i % 4) == 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_display_sequencer.md
# debug_display_sequencer

Sequencer for the debug VGA overlay. Generates 640x480@60 raster timing (800x525 total) and the x/y scan coordinates consumed by the pixel renderer. Captures a tear-free snapshot of the CPU debug bus once per frame at the start of vertical blanking, so every pixel of a frame shows one consistent CPU state. Supports freeze and single-step capture for stepping through pipeline state on screen.

## Interface
Parameters:
- DBG_W, 256, width of the debug snapshot bus: register heap 176 + IfPC 16 + IfIR 16 + four 4-bit register indices 16 + ExCalResult 16 + MeCalResult 16.
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixels.
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pix_en  in  1  pixel-rate clock enable (25 MHz tick); counters advance only when high.
- dbg_in  in  DBG_W  live CPU debug bus.
- freeze  in  1  level; hold the current snapshot.
- step  in  1  one-cycle pulse; request one capture while frozen.
- x, y  out  11  current scan coordinates (horizontal count, vertical count).
- hsync, vsync  out  1  active-low sync.
- active  out  1  high when x<640 and y<480.
- frame_start  out  1  one-cycle pulse on wrap to (0,0).
- dbg_out  out  DBG_W  frozen snapshot fed to the renderer.
- snap_valid  out  1  high once at least one capture has occurred since reset.
- step_ack  out  1  one-cycle pulse when a step capture completes.

## Operation
- Counters: x counts 0..799; at 799 with pix_en, x→0 and y increments; y counts 0..524, wraps to 0. No change without pix_en.
- hsync low for x in 656..751; vsync low for y in 490..491. All of hsync/vsync/active are registered and computed from the next counter values, so they change on the same edge as x/y.
- Capture event (CE): the edge where (x,y) becomes (0,480). At CE, if capture is permitted, dbg_out←dbg_in and snap_valid←1.
- Capture FSM, states LIVE, HOLD, ARMED:
  - LIVE: capture at every CE. freeze=1 → HOLD on that edge. A CE on the same edge is suppressed, because freeze has priority.
  - HOLD: no capture. freeze=0 → LIVE. step=1 (with freeze=1) → ARMED. A CE on the same edge as step is not used; capture happens at the next CE.
  - ARMED: at CE, capture, pulse step_ack, → HOLD. If freeze=0 first → LIVE with no step_ack; LIVE then captures at the next CE. step in ARMED is ignored.
- step in LIVE is ignored.

## Timing
- Reset values: x=0, y=0, hsync=1, vsync=1, active=1, frame_start=0, dbg_out=0, snap_valid=0, step_ack=0, FSM=LIVE.
- rst mid-frame restarts the raster at (0,0) on the next edge and discards the snapshot; frame_start does not pulse on reset.
- Snapshot latency: dbg_out is valid on the edge after the cycle where dbg_in is sampled at CE. It is stable for the entire following visible frame.
- frame_start and step_ack are exactly one clk wide, even if pix_en is held high continuously.
- Renderer output is combinational on x/y, so pixel data aligns with hsync/vsync with zero added latency.

## Structure
- Package debug_display_pkg holds:
  - the timing constants and derived totals (H_TOT=800, V_TOT=525);
  - the capture FSM state enum;
  - the DBG_W field offsets for slicing dbg_out into renderer inputs.
- Sub-module vga_timing_counter holds the x/y counters, sync/active generation, frame_start, and the CE strobe. debug_display_sequencer instantiates it and adds the capture FSM and snapshot register.

## Test plan
- Reset, then pix_en held high: x wraps 799→0 after 800 clocks; hsync low for exactly 96 clocks starting at x=656; vsync low for y=490..491; frame_start pulses every 420000 clocks.
- LIVE: dbg_in=A until CE, then B. dbg_out=A from the edge after CE through the whole next frame, and snap_valid=1.
- freeze asserted on the CE edge with dbg_in=C: no capture, dbg_out keeps its previous value, FSM=HOLD.
- HOLD plus step pulse mid-frame, dbg_in=D at the next CE: dbg_out=D, step_ack pulses once, FSM returns to HOLD, and the following CE with dbg_in=E leaves dbg_out=D.
- ARMED, then freeze deasserted before CE: no step_ack; capture resumes every CE.
- rst asserted at (300,200): next edge x=0, y=0, dbg_out=0, snap_valid=0, no frame_start pulse. pix_en toggled at 1-in-4 rate: counters advance only on enabled cycles.
